// File: rtl/pc_sequencer.sv
// Program-counter owner and fetch sequencer for the RV32 single-cycle core.
// Optional misaligned-branch trap enabled by defining PC_SEQ_MISALIGN_TRAP_EN.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        halt_req,
   output logic        halted,
   output logic        trap,
   output logic [31:0] trap_addr
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_instr_valid;
   logic        r_imem_req;
   logic        r_halted;

   logic        w_accept;
   logic        w_take_branch;
   logic [31:0] w_branch_pc;

   assign w_accept      = (r_state == S_EXEC) && !stall;
   assign w_take_branch = w_accept && !halt_req && branch_taken;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
   logic        r_trap;
   logic [31:0] r_trap_addr;
   logic        w_misaligned;

   assign w_misaligned = (branch_target[1:0] != 2'b00);
   assign w_branch_pc  = w_misaligned ? TRAP_VECTOR : branch_target;

   // trap pulses during the first FETCH cycle after the offending branch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_trap      <= 1'b0;
         r_trap_addr <= 32'h0000_0000;
      end else begin
         r_trap <= w_take_branch && w_misaligned;
         if (w_take_branch && w_misaligned) begin
            r_trap_addr <= branch_target;
         end
      end
   end

   assign trap      = r_trap;
   assign trap_addr = r_trap_addr;
`else
   logic w_unused_trap;

   assign w_branch_pc   = {branch_target[31:2], 2'b00};
   assign trap          = 1'b0;
   assign trap_addr     = 32'h0000_0000;
   assign w_unused_trap = ^{TRAP_VECTOR, branch_target[1:0]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_BOOT;
         r_pc          <= RESET_VECTOR;
         r_instr       <= NOP;
         r_instr_valid <= 1'b0;
         r_imem_req    <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         case (r_state)
            S_BOOT: begin
               r_state    <= S_FETCH;
               r_imem_req <= 1'b1;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  r_instr       <= imem_rdata;
                  r_state       <= S_EXEC;
                  r_imem_req    <= 1'b0;
                  r_instr_valid <= 1'b1;
               end
            end
            S_EXEC: begin
               // a stalled slot ignores redirect and halt requests entirely
               if (!stall) begin
                  r_instr_valid <= 1'b0;
                  if (halt_req) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_state    <= S_FETCH;
                     r_imem_req <= 1'b1;
                     if (branch_taken) begin
                        r_pc <= w_branch_pc;
                     end else begin
                        r_pc <= r_pc + 32'd4;
                     end
                  end
               end
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_BOOT;
            end
         endcase
      end
   end

   assign imem_req    = r_imem_req;
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign instr       = r_instr;
   assign instr_valid = r_instr_valid;
   assign halted      = r_halted;

   logic w_unused_accept;
   assign w_unused_accept = w_accept;

endmodule
